// File: rtl/ysyx_24100005_mem_pkg.sv
// Shared types and helpers for the synthesizable load/store memory responder.
// Holds the FSM state encoding, lane constants and the address-fault check.
package ysyx_24100005_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int WORD_BYTES = 4;
  localparam int MASK_W     = 4;

  // Offset compare is one bit wider so the range limit never overflows;
  // addresses below the base fault explicitly instead of wrapping into range.
  function automatic logic addr_fault(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input int unsigned depth_log2);
    logic [31:0] offset;
    logic [32:0] limit;
    offset = addr - base;
    limit  = 33'(WORD_BYTES) << depth_log2;
    return (addr[1:0] != 2'b00) || (addr < base) || ({1'b0, offset} >= limit);
  endfunction

endpackage

// File: rtl/ysyx_24100005_mem_array.sv
// Word storage split into byte lanes: byte-masked synchronous write and
// combinational read by word index.
module ysyx_24100005_mem_array
  import ysyx_24100005_mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [MASK_W-1:0]     wmask,
  input  logic [31:0]           wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [31:0]           rdata
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  // One array per byte lane so each lane has a single writer.
  for (genvar gi = 0; gi < MASK_W; gi++) begin : g_lane
    logic [7:0] lane_q [DEPTH];

    always_ff @(posedge clk) begin
      if (we && wmask[gi]) begin
        lane_q[waddr] <= wdata[8*gi +: 8];
      end
    end

    assign rdata[8*gi +: 8] = lane_q[raddr];
  end

endmodule

// File: rtl/ysyx_24100005_mem_resp.sv
// Single-outstanding memory responder: accepts a request, waits LATENCY
// cycles, performs the access and holds a registered response until taken.
module ysyx_24100005_mem_resp
  import ysyx_24100005_mem_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_latency_check
    $error("ysyx_24100005_mem_resp: LATENCY must be in 1..15");
  end

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        wen_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  wmask_q;

  logic        enter_resp;
  logic        mem_we;
  logic        cur_wen, cur_err;
  logic [31:0] cur_addr, cur_wdata, cur_offset, arr_rdata;
  logic [3:0]  cur_wmask;

  // With LATENCY==1 the access happens on the handshake edge itself, so the
  // live request fields are used while IDLE and the latched copy otherwise.
  assign cur_wen    = (state_q == IDLE) ? req_wen   : wen_q;
  assign cur_addr   = (state_q == IDLE) ? req_addr  : addr_q;
  assign cur_wdata  = (state_q == IDLE) ? req_wdata : wdata_q;
  assign cur_wmask  = (state_q == IDLE) ? req_wmask : wmask_q;
  assign cur_offset = cur_addr - BASE_ADDR;
  assign cur_err    = addr_fault(cur_addr, BASE_ADDR, DEPTH_LOG2);
  assign mem_we     = enter_resp && cur_wen && !cur_err;

  ysyx_24100005_mem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .waddr(cur_offset[DEPTH_LOG2+1:2]),
    .wmask(cur_wmask),
    .wdata(cur_wdata),
    .raddr(cur_offset[DEPTH_LOG2+1:2]),
    .rdata(arr_rdata)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (LATENCY == 1) begin
            enter_resp = 1'b1;
            state_d    = RESP;
          end else begin
            cnt_d   = 4'(LATENCY - 1);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          enter_resp = 1'b1;
          state_d    = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (enter_resp) begin
      err_d   = cur_err;
      rdata_d = (cur_err || cur_wen) ? 32'h0 : arr_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (req_valid && state_q == IDLE) begin
      wen_q   <= req_wen;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      wmask_q <= req_wmask;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_ysyx_24100005_mem_resp.sv
// Directed bench: four responders with LATENCY 2, 3, 1 and 15 exercised by
// per-feature tasks with hand-computed expected values.
module tb_ysyx_24100005_mem_resp;

  logic        clk;
  logic        rst       [4];
  logic        req_valid [4];
  logic        req_ready [4];
  logic        req_wen   [4];
  logic [31:0] req_addr  [4];
  logic [31:0] req_wdata [4];
  logic [3:0]  req_wmask [4];
  logic        rsp_valid [4];
  logic        rsp_ready [4];
  logic [31:0] rsp_rdata [4];
  logic        rsp_err   [4];

  int passed = 0;
  int total  = 0;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    ysyx_24100005_mem_resp #(
      .LATENCY((gi == 0) ? 2 : (gi == 1) ? 3 : (gi == 2) ? 1 : 15)
    ) u_dut (
      .clk      (clk),
      .rst      (rst[gi]),
      .req_valid(req_valid[gi]),
      .req_ready(req_ready[gi]),
      .req_wen  (req_wen[gi]),
      .req_addr (req_addr[gi]),
      .req_wdata(req_wdata[gi]),
      .req_wmask(req_wmask[gi]),
      .rsp_valid(rsp_valid[gi]),
      .rsp_ready(rsp_ready[gi]),
      .rsp_rdata(rsp_rdata[gi]),
      .rsp_err  (rsp_err[gi])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Full transaction; lat counts cycles from the handshake cycle to the first
  // rsp_valid cycle. hold>0 stalls rsp_ready while a second request waits.
  task automatic do_txn(input int k, input logic wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wmask,
                        input int hold, output logic [31:0] rdata,
                        output logic err, output int lat);
    int n;
    @(negedge clk);
    req_valid[k] = 1'b1;
    req_wen[k]   = wen;
    req_addr[k]  = addr;
    req_wdata[k] = wdata;
    req_wmask[k] = wmask;
    rsp_ready[k] = 1'b0;
    n = 0;
    while (!req_ready[k] && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    req_valid[k] = 1'b0;
    lat = 1;
    while (!rsp_valid[k] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rdata = rsp_rdata[k];
    err   = rsp_err[k];
    if (hold > 0) begin
      req_valid[k] = 1'b1;
      req_wen[k]   = 1'b0;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      total++;
      if (rsp_valid[k] !== 1'b1 || rsp_rdata[k] !== rdata || rsp_err[k] !== err ||
          req_ready[k] !== 1'b0)
        $display("FAIL hold_stable[%0d]: got valid=%b rdata=%h err=%b ready=%b required valid=1 rdata=%h err=%b ready=0",
                 i, rsp_valid[k], rsp_rdata[k], rsp_err[k], req_ready[k], rdata, err);
      else passed++;
    end
    rsp_ready[k] = 1'b1;
    @(negedge clk);
    rsp_ready[k] = 1'b0;
    if (hold > 0) begin
      req_valid[k] = 1'b0;
      total++;
      if (req_ready[k] !== 1'b1 || rsp_valid[k] !== 1'b0)
        $display("FAIL ready_after_rsp: got ready=%b valid=%b required ready=1 valid=0",
                 req_ready[k], rsp_valid[k]);
      else passed++;
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 4; k++) begin
      total++;
      if (req_ready[k] !== 1'b1 || rsp_valid[k] !== 1'b0 ||
          rsp_rdata[k] !== 32'h0 || rsp_err[k] !== 1'b0)
        $display("FAIL reset[%0d]: got ready=%b valid=%b rdata=%h err=%b required 1 0 00000000 0",
                 k, req_ready[k], rsp_valid[k], rsp_rdata[k], rsp_err[k]);
      else passed++;
    end
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic er; int lat;
    do_txn(0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, rd, er, lat);
    total++;
    if (rd !== 32'h0 || er !== 1'b0 || lat != 2)
      $display("FAIL write_full: got rdata=%h err=%b lat=%0d required 00000000 0 2", rd, er, lat);
    else passed++;
    do_txn(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 0, rd, er, lat);
    total++;
    if (rd !== 32'hDEAD_BEEF || er !== 1'b0 || lat != 2)
      $display("FAIL read_full: got rdata=%h err=%b lat=%0d required deadbeef 0 2", rd, er, lat);
    else passed++;
  endtask

  task automatic test_byte_mask();
    logic [31:0] rd; logic er; int lat;
    do_txn(0, 1'b1, 32'h8000_0010, 32'h00AA_0000, 4'b0100, 0, rd, er, lat);
    do_txn(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 0, rd, er, lat);
    total++;
    if (rd !== 32'hDEAA_BEEF || er !== 1'b0)
      $display("FAIL byte_mask: got rdata=%h err=%b required deaabeef 0", rd, er);
    else passed++;
    do_txn(0, 1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'b0000, 0, rd, er, lat);
    total++;
    if (er !== 1'b0 || rd !== 32'h0)
      $display("FAIL mask_zero_err: got rdata=%h err=%b required 00000000 0", rd, er);
    else passed++;
    do_txn(0, 1'b0, 32'h8000_0010, 32'h0, 4'hF, 0, rd, er, lat);
    total++;
    if (rd !== 32'hDEAA_BEEF)
      $display("FAIL mask_zero_data: got rdata=%h required deaabeef", rd);
    else passed++;
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat;
    logic [31:0] addrs [3] = '{32'h8000_0002, 32'h7FFF_FFFC, 32'h8000_1000};
    for (int i = 0; i < 3; i++) begin
      do_txn(0, 1'b0, addrs[i], 32'h0, 4'hF, 0, rd, er, lat);
      total++;
      if (er !== 1'b1 || rd !== 32'h0)
        $display("FAIL err_read %h: got rdata=%h err=%b required 00000000 1", addrs[i], rd, er);
      else passed++;
    end
    do_txn(0, 1'b1, 32'h8000_0FFC, 32'h1234_5678, 4'hF, 0, rd, er, lat);
    do_txn(0, 1'b0, 32'h8000_0FFC, 32'h0, 4'h0, 0, rd, er, lat);
    total++;
    if (er !== 1'b0 || rd !== 32'h1234_5678)
      $display("FAIL top_word: got rdata=%h err=%b required 12345678 0", rd, er);
    else passed++;
    do_txn(0, 1'b1, 32'h8000_0012, 32'hFFFF_FFFF, 4'hF, 0, rd, er, lat);
    total++;
    if (er !== 1'b1 || rd !== 32'h0)
      $display("FAIL err_write: got rdata=%h err=%b required 00000000 1", rd, er);
    else passed++;
    do_txn(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 0, rd, er, lat);
    total++;
    if (rd !== 32'hDEAA_BEEF)
      $display("FAIL err_no_update: got rdata=%h required deaabeef", rd);
    else passed++;
  endtask

  task automatic test_hold();
    logic [31:0] rd; logic er; int lat;
    do_txn(0, 1'b0, 32'h8000_0FFC, 32'h0, 4'h0, 5, rd, er, lat);
    total++;
    if (rd !== 32'h1234_5678 || er !== 1'b0)
      $display("FAIL hold_data: got rdata=%h err=%b required 12345678 0", rd, er);
    else passed++;
  endtask

  task automatic test_rst_mid();
    logic [31:0] rd; logic er; int lat; logic seen;
    do_txn(1, 1'b1, 32'h8000_0020, 32'h1111_1111, 4'hF, 0, rd, er, lat);
    do_txn(1, 1'b0, 32'h8000_0020, 32'h0, 4'h0, 0, rd, er, lat);
    total++;
    if (rd !== 32'h1111_1111 || lat != 3)
      $display("FAIL lat3_read: got rdata=%h lat=%0d required 11111111 3", rd, lat);
    else passed++;
    @(negedge clk);
    req_valid[1] = 1'b1; req_wen[1] = 1'b1; req_addr[1] = 32'h8000_0020;
    req_wdata[1] = 32'h2222_2222; req_wmask[1] = 4'hF;
    @(negedge clk);
    req_valid[1] = 1'b0;
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    total++;
    if (req_ready[1] !== 1'b1 || rsp_valid[1] !== 1'b0 || rsp_rdata[1] !== 32'h0 || rsp_err[1] !== 1'b0)
      $display("FAIL rst_wait_outputs: got ready=%b valid=%b rdata=%h err=%b required 1 0 00000000 0",
               req_ready[1], rsp_valid[1], rsp_rdata[1], rsp_err[1]);
    else passed++;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid[1] !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) $display("FAIL rst_no_rsp: got rsp_valid=1 required 0");
    else passed++;
    do_txn(1, 1'b0, 32'h8000_0020, 32'h0, 4'h0, 0, rd, er, lat);
    total++;
    if (rd !== 32'h1111_1111)
      $display("FAIL rst_no_write: got rdata=%h required 11111111", rd);
    else passed++;
  endtask

  task automatic test_back_to_back(input int k, input int exp_lat, input int exp_gap);
    logic [31:0] rd; logic er; int lat;
    int hs_cyc [$];
    do_txn(k, 1'b1, 32'h8000_0040, 32'hCAFE_F00D, 4'hF, 0, rd, er, lat);
    total++;
    if (lat != exp_lat)
      $display("FAIL latency[%0d]: got %0d required %0d", k, lat, exp_lat);
    else passed++;
    req_valid[k] = 1'b1; req_wen[k] = 1'b0; req_addr[k] = 32'h8000_0040;
    rsp_ready[k] = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (req_ready[k]) hs_cyc.push_back(c);
    end
    req_valid[k] = 1'b0;
    repeat (20) @(negedge clk);
    rsp_ready[k] = 1'b0;
    total++;
    if (hs_cyc.size() < 3)
      $display("FAIL b2b_count[%0d]: got %0d handshakes required at least 3", k, hs_cyc.size());
    else passed++;
    for (int i = 1; i < hs_cyc.size() && i < 3; i++) begin
      total++;
      if (hs_cyc[i] - hs_cyc[i-1] != exp_gap)
        $display("FAIL b2b_gap[%0d]: got %0d required %0d", k, hs_cyc[i] - hs_cyc[i-1], exp_gap);
      else passed++;
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      rst[k] = 1'b1; req_valid[k] = 1'b0; req_wen[k] = 1'b0; req_addr[k] = 32'h0;
      req_wdata[k] = 32'h0; req_wmask[k] = 4'h0; rsp_ready[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) rst[k] = 1'b0;
    test_reset();
    test_write_read();
    test_byte_mask();
    test_errors();
    test_hold();
    test_rst_mid();
    test_back_to_back(2, 1, 2);
    test_back_to_back(3, 15, 16);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ysyx_24100005_mem_resp.md
Name: ysyx_24100005_mem_resp

Overview:
- Memory responder for the core's load/store requests; it is the other end of the request side the core drives.
- Accepts one request at a time on a valid/ready request channel.
- Waits a fixed latency, performs a byte-masked write or a word read on internal storage, then returns a response on a valid/ready response channel.
- Replaces the DPI memory call path with synthesizable storage for simulation and FPGA builds.

Parameters:
- DEPTH_LOG2, 10, storage depth as log2 of 32-bit word count (1024 words).
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- LATENCY, 2, cycles from request handshake to first rsp_valid cycle; legal range 1..15.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_wen  input  1  1 = write, 0 = read.
- req_addr  input  32  byte address.
- req_wdata  input  32  write data.
- req_wmask  input  4  byte enables; bit i enables wdata[8i+7:8i].
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester accepts response.
- rsp_rdata  output  32  read data; 0 for writes and for errors.
- rsp_err  output  1  access fault.

Behaviour:
- Single clock domain (clk). Reset is synchronous and active-high on rst.
- Reset state: FSM IDLE, req_ready=1 after reset, rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0. Storage contents are not reset.
- FSM states:
  - IDLE: req_ready=1, rsp_valid=0. On req_valid&&req_ready, latch wen/addr/wdata/wmask. Go to RESP if LATENCY==1, else go to WAIT with counter=LATENCY-1.
  - WAIT: req_ready=0. Decrement counter each cycle; when counter reaches 1, go to RESP next cycle.
  - Net latency: rsp_valid rises exactly LATENCY cycles after the handshake edge.
  - RESP entry (the same edge rsp_valid rises): compute the error, commit the write or capture read data, and register rsp_rdata/rsp_err.
  - RESP: req_ready=0, rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_valid&&rsp_ready; then return to IDLE with rsp_valid=0 on the next cycle.
- One outstanding transaction; no back-to-back overlap. Minimum spacing between handshakes is LATENCY+1 cycles.
- No combinational path from any req_* or rsp_ready input to rsp_* outputs. req_ready depends on state only.
- Address decode:
  - word index = (addr - BASE_ADDR) >> 2, using 32-bit unsigned subtract.
  - err = addr[1:0]!=0 OR addr < BASE_ADDR OR (addr - BASE_ADDR) >= 4<<DEPTH_LOG2.
  - Top in-range address BASE_ADDR + 4*2^DEPTH_LOG2 - 4 is legal; the next word faults. Wrap-around below BASE must fault, not alias.
- On error: no storage update, rsp_rdata=0, rsp_err=1.
- Write: only bytes with wmask=1 change. wmask=4'b0000 is a legal no-op write with err=0. rsp_rdata=0.
- Read: rsp_rdata = full stored word; wmask ignored.
- Read after write to the same word returns the written data. Ordering is guaranteed by single outstanding.
- Holding req_valid while not ready: the request is ignored until IDLE; inputs may change freely until accepted.
- rst asserted in WAIT: transaction dropped, no write committed. rst in RESP: response dropped; any write already committed stays committed.
- Elaboration check: LATENCY outside 1..15 triggers a $error.

Decomposition:
- Package ysyx_24100005_mem_pkg holds:
  - state typedef (IDLE, WAIT, RESP), 2-bit encoding;
  - constants WORD_BYTES=4 and MASK_W=4;
  - an address-fault helper function.
- Sub-module ysyx_24100005_mem_array: 2^DEPTH_LOG2 x 32 storage with byte-masked synchronous write and combinational read by index. The responder owns the FSM, counter, decode and output registers.

Test Plan:
- Write 0xDEADBEEF mask 4'hF to 0x8000_0010, then read 0x8000_0010 -> read rsp_rdata=0xDEADBEEF, err=0; rsp_valid rises exactly 2 cycles after each handshake.
- After the above, write 0x00AA_0000 mask 4'b0100 to 0x8000_0010, then read -> 0xDEAABEEF.
- Read 0x8000_0002 (misaligned), 0x7FFF_FFFC, and 0x8000_1000 (just past top) -> err=1, rdata=0. Read 0x8000_0FFC -> err=0.
- Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_rdata and rsp_err stable; req_ready=0; a second req_valid is not accepted until the cycle after rsp handshake.
- Assert rst one cycle after accepting a write to 0x8000_0020 (LATENCY=3) -> no response; a later read of 0x8000_0020 returns the old contents. All outputs are at reset values the cycle after rst.
- Sweep LATENCY=1 and 15 with back-to-back requests and rsp_ready=1 -> handshake spacing equals LATENCY+1 cycles.
